// File: rtl/mem_wb_stage.sv
// Memory + write-back stage: issues one data-memory access per load/store,
// aligns load data and drives a single-cycle register-file write.
module mem_wb_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_wb_sel,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_pc_plus4,
  output logic        ex_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_write_enable,
  output logic [4:0]  wb_write_address,
  output logic [31:0] wb_write_data,
  output logic        misalign_err,
  output logic        bus_err
);
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          r_reg_write;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;

  logic          accept, ex_is_mem, ex_mis, cnt_last;
  logic [3:0]    ex_wmask;
  logic [31:0]   ex_wdata, load_data;

  assign ex_ready  = (state != MEM);
  assign dmem_req  = (state == MEM);
  assign accept    = ex_valid && ex_ready;
  assign ex_is_mem = ex_is_store || (ex_wb_sel == 2'b01);
  assign ex_mis    = ex_is_mem &&
                     (((ex_funct3[1:0] == 2'b01) && ex_alu_result[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00)));
  assign cnt_last  = (cnt == CW'(ACK_TIMEOUT - 1));

  always_comb begin
    ex_wmask = 4'b1111;
    ex_wdata = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        ex_wmask = 4'b0001 << ex_alu_result[1:0];
        ex_wdata = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        ex_wmask = 4'b0011 << ex_alu_result[1:0];
        ex_wdata = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte/halfword lane picked by the low address bits captured at accept.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dmem_rdata[{r_off, 3'b000} +: 8];
    h = dmem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  load_data = {{24{b[7]}}, b};
      3'b100:  load_data = {24'd0, b};
      3'b001:  load_data = {{16{h[15]}}, h};
      3'b101:  load_data = {16'd0, h};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      r_reg_write      <= 1'b0;
      r_funct3         <= 3'd0;
      r_off            <= 2'd0;
      dmem_we          <= 1'b0;
      dmem_addr        <= 32'd0;
      dmem_wdata       <= 32'd0;
      dmem_wmask       <= 4'd0;
      wb_write_enable  <= 1'b0;
      wb_write_address <= 5'd0;
      wb_write_data    <= 32'd0;
      misalign_err     <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      wb_write_enable <= 1'b0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
      case (state)
        MEM: begin
          if (dmem_ack) begin
            if (dmem_we) begin
              state <= IDLE;
            end else begin
              state           <= WB;
              wb_write_enable <= r_reg_write && (wb_write_address != 5'd0);
              wb_write_data   <= load_data;
            end
          end else if (cnt_last) begin
            state   <= IDLE;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            r_reg_write      <= ex_reg_write;
            r_funct3         <= ex_funct3;
            r_off            <= ex_alu_result[1:0];
            wb_write_address <= ex_rd;
            cnt              <= '0;
            if (ex_is_mem && !ex_mis) begin
              state      <= MEM;
              dmem_we    <= ex_is_store;
              dmem_addr  <= {ex_alu_result[31:2], 2'b00};
              dmem_wdata <= ex_wdata;
              dmem_wmask <= ex_wmask;
            end else begin
              // Non-memory ops and misaligned accesses finish in one WB cycle.
              state           <= WB;
              misalign_err    <= ex_mis;
              wb_write_enable <= ex_reg_write && (ex_rd != 5'd0) && !ex_mis;
              wb_write_data   <= (ex_wb_sel == 2'b10) ? ex_pc_plus4 : ex_alu_result;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver pushes expectations, a memory
// responder and a write-back monitor pop and compare them.
module tb_mem_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid = 1'b0, ex_reg_write = 1'b0, ex_is_store = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ex_wb_sel = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0, ex_pc_plus4 = '0;
  logic        ex_ready, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        wb_write_enable, misalign_err, bus_err;
  logic [4:0]  wb_write_address;
  logic [31:0] wb_write_data;

  mem_wb_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_pc_plus4(ex_pc_plus4), .ex_ready(ex_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_write_enable(wb_write_enable),
    .wb_write_address(wb_write_address), .wb_write_data(wb_write_data),
    .misalign_err(misalign_err), .bus_err(bus_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int ack_cyc = -10;

  // kind: 0 register write, 1 misalign pulse, 2 bus error; at<0 means ack+1
  typedef struct { int kind; logic [4:0] rd; logic [31:0] data; int at; } wb_t;
  // delay: ack in that request cycle; -1 never (timeout); -2 killed by reset
  typedef struct { logic [31:0] addr; logic we; logic [3:0] wmask; logic [31:0] wdata;
                   logic [31:0] rdata; int delay; int at; } bus_t;
  wb_t  wbq[$];
  bus_t busq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Issue one instruction starting at a negedge; returns at the negedge after accept.
  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] sd, input logic [31:0] pc4,
                      input logic [31:0] rdata, input int delay);
    int w, size, off, c;
    bit mem, mis;
    wb_t e;
    bus_t b;
    longint v;
    ex_valid = 1'b1; ex_reg_write = rw; ex_rd = rd; ex_wb_sel = sel;
    ex_is_store = st; ex_funct3 = f3; ex_alu_result = a; ex_store_data = sd;
    ex_pc_plus4 = pc4;
    w = 0;
    while (!ex_ready && w < 20) begin @(negedge clk); w++; end
    if (!ex_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: ex_ready stuck low");
      ex_valid = 1'b0;
      return;
    end
    c    = cyc;
    size = 1 << f3[1:0];
    off  = int'(a[1:0]);
    mem  = st || (sel == 2'b01);
    mis  = mem && ((int'(a[1:0]) % size) != 0);
    if (mis) begin
      e = '{1, rd, 32'd0, c + 1}; wbq.push_back(e);
    end else if (mem) begin
      b.addr = a & 32'hFFFF_FFFC; b.we = st; b.wmask = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
      b.rdata = rdata; b.delay = delay; b.at = c + 1;
      busq.push_back(b);
      if (delay == -1) begin
        e = '{2, rd, 32'd0, c + 1 + TO}; wbq.push_back(e);
      end else if (delay >= 0 && !st && rw && rd != 0) begin
        v = longint'(rdata >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
        e = '{0, rd, v[31:0], -1}; wbq.push_back(e);
      end
    end else if (rw && rd != 0) begin
      e = '{0, rd, (sel == 2'b10) ? pc4 : a, c + 1}; wbq.push_back(e);
    end
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Memory responder: checks every request cycle, acks per the queued delay.
  initial begin
    bus_t cur;
    int n;
    bit busy;
    busy = 0; n = 0; dmem_ack = 1'b0; dmem_rdata = '0;
    cur = '{32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 0};
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (!busy) begin
          if (busq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: dmem_req=1 addr %h with nothing pending", dmem_addr);
            cur = '{dmem_addr, dmem_we, dmem_wmask, dmem_wdata, 32'd0, 0, cyc};
          end else cur = busq.pop_front();
          busy = 1; n = 0;
          chk("req_start_cycle", 32'(cyc), 32'(cur.at));
        end
        chk("dmem_addr", dmem_addr, cur.addr);
        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
        chk("dmem_wmask", 32'(dmem_wmask), 32'(cur.wmask));
        chk("dmem_wdata", dmem_wdata, cur.wdata);
        if (n == cur.delay) begin
          dmem_ack = 1'b1; dmem_rdata = cur.rdata; ack_cyc = cyc;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        n++;
      end else begin
        if (busy && cur.delay == -1) chk("req_cycles_timeout", 32'(n), 32'(TO));
        busy = 0;
        // Stray acks while no request is outstanding must be ignored.
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Write-back monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (!rst && (wb_write_enable || misalign_err || bus_err)) begin
        if (wbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: we=%0b rd=%0d data=%h mis=%0b bus=%0b",
                   wb_write_enable, wb_write_address, wb_write_data, misalign_err, bus_err);
        end else begin
          e = wbq.pop_front();
          chk("wb_write_enable", 32'(wb_write_enable), 32'(e.kind == 0));
          chk("misalign_err", 32'(misalign_err), 32'(e.kind == 1));
          chk("bus_err", 32'(bus_err), 32'(e.kind == 2));
          if (e.kind == 0) begin
            chk("wb_write_address", 32'(wb_write_address), 32'(e.rd));
            chk("wb_write_data", wb_write_data, e.data);
          end
          chk("wb_latency", 32'(cyc), 32'((e.at < 0) ? ack_cyc + 1 : e.at));
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_wmask", 32'(dmem_wmask), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_wb_en", 32'(wb_write_enable), 32'd0);
    chk("rst_wb_addr", 32'(wb_write_address), 32'd0);
    chk("rst_wb_data", wb_write_data, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
  endtask

  logic [2:0] ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    int w, k, dly;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // ALU op, rd=5: write only in the cycle after accept
    send(1, 5'd5, 2'b00, 0, 3'b000, 32'h1234, 32'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    chk("alu_single_cycle_we", 32'(wb_write_enable), 32'd0);
    // LB / LBU at 0x103, ack in third request cycle
    send(1, 5'd3, 2'b01, 0, 3'b000, 32'h103, 32'd0, 32'd0, 32'h80FF_0000, 2);
    repeat (5) @(negedge clk);
    send(1, 5'd4, 2'b01, 0, 3'b100, 32'h103, 32'd0, 32'd0, 32'h80FF_0000, 2);
    repeat (5) @(negedge clk);
    // SH at 0x202
    send(0, 5'd9, 2'b00, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'd0, 32'd0, 1);
    repeat (4) @(negedge clk);
    // Misaligned LW: no request, misalign pulse only
    send(1, 5'd6, 2'b01, 0, 3'b010, 32'h101, 32'd0, 32'd0, 32'd0, 0);
    chk("misaligned_no_req", 32'(dmem_req), 32'd0);
    repeat (2) @(negedge clk);
    // Timeout with no ack
    send(1, 5'd8, 2'b01, 0, 3'b010, 32'h40, 32'd0, 32'd0, 32'd0, -1);
    repeat (TO + 3) @(negedge clk);
    // Back-to-back ALU ops to rd=0 then rd=7
    send(1, 5'd0, 2'b00, 0, 3'b000, 32'h1111, 32'd0, 32'd0, 32'd0, 0);
    chk("b2b_ex_ready", 32'(ex_ready), 32'd1);
    send(1, 5'd7, 2'b00, 0, 3'b000, 32'h7777, 32'd0, 32'd0, 32'd0, 0);
    repeat (2) @(negedge clk);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 3);
      a = $urandom;
      if (k >= 2) a = {24'd0, a[7:0]};
      dly = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 3);
      case (k)
        0: send($urandom_range(0, 7) != 0, 5'($urandom), 2'b00, 0, 3'($urandom), a,
                $urandom, $urandom, 32'd0, 0);
        1: send($urandom_range(0, 7) != 0, 5'($urandom), 2'b10, 0, 3'($urandom), a,
                $urandom, $urandom, 32'd0, 0);
        2: send($urandom_range(0, 7) != 0, 5'($urandom), 2'b01, 0,
                ld_f3[$urandom_range(0, 4)], a, $urandom, $urandom, $urandom, dly);
        default: send($urandom_range(0, 1), 5'($urandom), 2'b00, 1,
                      3'($urandom_range(0, 2)), a, $urandom, $urandom, $urandom, dly);
      endcase
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    w = 0;
    while ((wbq.size() != 0 || busq.size() != 0) && w < 100) begin @(negedge clk); w++; end

    // Reset raised mid-MEM: request drops at once, late ack does nothing
    send(1, 5'd10, 2'b01, 0, 3'b010, 32'h80, 32'd0, 32'd0, 32'hDEAD_BEEF, -2);
    #2 rst = 1'b1;
    #1 chk("rst_mid_mem_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_mem_ready", 32'(ex_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    repeat (6) @(negedge clk);

    chk("wbq_drained", 32'(wbq.size()), 32'd0);
    chk("busq_drained", 32'(busq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: maximum number of MEM-state cycles spent waiting for dmem_ack before abort.
REQ-002 SHALL have ports clk (in, 1) as the single clock and rst (in, 1) as the reset; reset is asynchronous and active-high.
REQ-003 SHALL have inputs ex_valid 1, ex_reg_write 1, ex_rd 5, ex_wb_sel 2 (00 ALU, 01 load, 10 pc+4), ex_is_store 1, ex_funct3 3, ex_alu_result 32 (result or address), ex_store_data 32 and ex_pc_plus4 32.
REQ-004 SHALL have output ex_ready 1: the stage accepts an instruction when ex_valid and ex_ready are both high.
REQ-005 SHALL have outputs dmem_req 1, dmem_we 1, dmem_addr 32, dmem_wdata 32 and dmem_wmask 4, and inputs dmem_ack 1 and dmem_rdata 32.
REQ-006 SHALL have outputs wb_write_enable 1, wb_write_address 5 and wb_write_data 32, which drive the register-file write port.
REQ-007 SHALL have outputs misalign_err 1 and bus_err 1, each a one-cycle error pulse.

Function
REQ-008 SHALL use FSM states IDLE, MEM and WB.
REQ-009 SHALL drive ex_ready = (state != MEM).
REQ-010 On accept, SHALL register all ex_* fields into the stage.
REQ-011 On accept of a non-memory instruction (wb_sel != 01 and !is_store), SHALL transition to WB.
REQ-012 On accept of an aligned load or store, SHALL transition to MEM.
REQ-013 On accept of a misaligned access, SHALL transition to WB with the write suppressed.
REQ-014 SHALL treat an access as misaligned when it is halfword (funct3[1:0]=01) with addr[0]=1, or word (funct3[1:0]=10) with addr[1:0]!=0.
REQ-015 SHALL assert dmem_req in every MEM cycle and deassert it in all other states.
REQ-016 SHALL hold dmem_addr, dmem_we, dmem_wdata and dmem_wmask stable while dmem_req is high.
REQ-017 SHALL drive dmem_addr = {alu_result[31:2], 2'b00} and dmem_we = is_store.
REQ-018 SHALL drive dmem_wmask for SB as 0001 shifted left by addr[1:0].
REQ-019 SHALL drive dmem_wmask for SH as 0011 shifted left by addr[1:0], and for SW as 1111.
REQ-020 SHALL drive dmem_wdata with store_data[7:0] replicated x4 for SB, store_data[15:0] replicated x2 for SH, and store_data for SW.
REQ-021 In MEM with dmem_ack=1, a load SHALL capture aligned read data and go to WB.
REQ-022 In MEM with dmem_ack=1, a store SHALL go to IDLE and perform no write-back.
REQ-023 SHALL extract load data by selecting the byte/halfword at addr[1:0]; funct3 000/001 sign-extend, 100/101 zero-extend, 010 takes the whole word.
REQ-024 SHALL count MEM cycles with a counter cleared on entry to MEM.
REQ-025 If the count reaches ACK_TIMEOUT with dmem_ack=0, SHALL drop dmem_req, pulse bus_err for one cycle and go to IDLE with no write-back.
REQ-026 A dmem_ack seen outside MEM SHALL be ignored.
REQ-027 In WB, SHALL assert wb_write_enable = reg_write && rd != 0 && !misaligned for exactly one cycle.
REQ-028 SHALL drive wb_write_address = rd.
REQ-029 SHALL drive wb_write_data from ALU result, aligned load data or pc_plus4 according to wb_sel.
REQ-030 SHALL pulse misalign_err in the WB cycle of a misaligned instruction.
REQ-031 In WB with a new accept, SHALL go directly to that instruction's next state (back-to-back, no bubble); otherwise SHALL go to IDLE.
REQ-032 Non-memory latency SHALL be: accept at cycle N gives the register write at cycle N+1.
REQ-033 Load latency SHALL be: accept at N, dmem_req from N+1, ack at cycle A, register write at A+1.
REQ-034 wb_write_data SHALL be registered; no combinational path SHALL exist from dmem_rdata to the wb_* outputs.

Reset
REQ-035 While rst is high, state SHALL be IDLE and ex_ready=1.
REQ-036 While rst is high, dmem_req, dmem_we, dmem_wmask, wb_write_enable, misalign_err and bus_err SHALL be 0.
REQ-037 While rst is high, dmem_addr, dmem_wdata, wb_write_address, wb_write_data and the timeout counter SHALL be 0.
REQ-038 Reset asserted mid-MEM SHALL drop dmem_req immediately (asynchronously), and a later dmem_ack SHALL produce no write-back.

Verification
REQ-039 ALU op rd=5, result 0x1234 accepted at cycle N -> wb_write_enable=1, addr 5, data 0x00001234 at N+1 only.
REQ-040 LB addr 0x103, rdata 0x80FF_0000, ack after 3 cycles -> dmem_addr 0x100, write data 0xFFFFFF80; LBU same access -> 0x00000080.
REQ-041 SH addr 0x202, store_data 0xABCD -> dmem_wmask 1100, dmem_wdata 0xABCDABCD, dmem_we=1, no write-back.
REQ-042 LW addr 0x101 -> no dmem_req, misalign_err pulse, wb_write_enable=0.
REQ-043 With ACK_TIMEOUT=4 and ack never asserted -> dmem_req high for 4 cycles, bus_err pulse, return to IDLE.
REQ-044 Back-to-back ALU ops to rd=0 then rd=7 -> ex_ready stays 1; only the rd=7 write is asserted; rst raised in MEM -> dmem_req 0 the same cycle.
